reset_release_sequencer: RTL and testbench
==========================================

# reset_release_sequencer

Consumes the device configuration-complete indication (`ninit_done`, active-low, asynchronous) and turns it into an ordered reset release for the transceiver/IO PLLs and the core fabric. It gates PLL reset on configuration done, waits for PLL lock with timeout and bounded retry, then releases the core reset after a programmable hold. It sits directly downstream of the reset-release IP and upstream of every block that takes a synchronous core reset.

## Interface
- `SYNC_STAGES`, 3: synchronizer depth for `ninit_done` and `pll_locked` (min 2).
- `HOLD_CYCLES`, 16: cycles spent in PLL_RST and in CORE_HOLD (min 1).
- `PLL_WAIT_CYCLES`, 256: lock timeout in PLL_WAIT (min 2).
- `MAX_RETRIES`, 3: lock timeouts tolerated before ERROR (1..15).

- `clk`  in  1  free-running clock, valid before configuration completes.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ninit_done`  in  1  async; 0 = device configuration complete.
- `pll_locked`  in  1  async; PLL lock indication.
- `sw_reset_req`  in  1  sync single-cycle request to rerun the sequence from PLL_RST.
- `pll_rst`  out  1  active-high PLL/transceiver reset.
- `core_rst_n`  out  1  active-low core reset, synchronous to `clk`.
- `rst_done`  out  1  1 while in RUN.
- `lock_err`  out  1  1 while in ERROR.
- `retry_cnt`  out  4  lock timeouts since last entry to IDLE or `sw_reset_req`.
- `state`  out  3  encoded state for debug: IDLE=0, PLL_RST=1, PLL_WAIT=2, CORE_HOLD=3, RUN=4, ERROR=5.

## Operation
- `ninit_done` and `pll_locked` each pass through a `SYNC_STAGES`-flop synchronizer reset to 1 and 0 respectively, giving `init_s` and `lock_s`. All FSM decisions use only the synchronized versions.
- A single counter `cnt` is shared by all timed states. It clears on every state change and saturates at its maximum. Width is clog2(max(HOLD_CYCLES, PLL_WAIT_CYCLES)) + 1.
- IDLE
  - Moves to PLL_RST when `init_s` = 0.
  - `retry_cnt` is held at 0.
- PLL_RST
  - After HOLD_CYCLES cycles, moves to PLL_WAIT.
- PLL_WAIT
  - `lock_s` = 1 -> CORE_HOLD.
  - Else, on the PLL_WAIT_CYCLES-th cycle -> `retry_cnt`+1. If the new value equals MAX_RETRIES, go to ERROR; otherwise go to PLL_RST.
- CORE_HOLD
  - `lock_s` = 0 -> PLL_RST. This does not count as a retry.
  - Else, after HOLD_CYCLES cycles -> RUN.
- RUN
  - `lock_s` = 0 -> PLL_RST. `retry_cnt` is unchanged.
- ERROR
  - Sticky. Exits only on `sw_reset_req` or `rst_n`.
- Global overrides, highest priority first:
  1. `init_s` = 1 in any state except IDLE -> IDLE.
  2. `sw_reset_req` in any state except IDLE -> PLL_RST, with `retry_cnt` cleared to 0. `sw_reset_req` in IDLE is ignored.
- Outputs are Moore, decoded from the registered state:
  - `pll_rst` = 1 in IDLE, PLL_RST and ERROR.
  - `core_rst_n` = 1 only in RUN.
  - `rst_done` = RUN.
  - `lock_err` = ERROR.
- Reset values (`rst_n` = 0):
  - state = IDLE, `pll_rst` = 1, `core_rst_n` = 0, `rst_done` = 0, `lock_err` = 0, `retry_cnt` = 0, `cnt` = 0.
  - Synchronizers are cleared.

## Timing
- An input transition sampled at edge k is visible on `init_s`/`lock_s` after edge k+SYNC_STAGES-1. The FSM acts on the following edge, so input-to-state latency is SYNC_STAGES cycles.
- PLL_RST and CORE_HOLD each last exactly HOLD_CYCLES cycles when uninterrupted.
- PLL_WAIT with a lock already present lasts exactly 1 cycle.
- A PLL_WAIT timeout lasts exactly PLL_WAIT_CYCLES cycles.
- If lock and timeout fall on the same cycle, lock wins and the FSM goes to CORE_HOLD.
- `sw_reset_req` arriving on the same cycle as a timeout wins: next state is PLL_RST and `retry_cnt` = 0.
- `core_rst_n` deassertion is always synchronous to `clk`. Assertion is asynchronous on `rst_n` and synchronous otherwise.
- `rst_n` asserted mid-sequence forces all outputs to their reset values immediately, with no wait for a clock edge.

## Test plan
Parameters for all scenarios: SYNC_STAGES=3, HOLD_CYCLES=16, PLL_WAIT_CYCLES=64, MAX_RETRIES=3. Edge 1 is the first edge that samples the stimulus.

- **Nominal release.** `pll_locked` = 1 throughout; `ninit_done` falls before edge 1.
  - PLL_RST entered at edge 4; `pll_rst` falls at edge 20.
  - CORE_HOLD at edge 21; `core_rst_n` = 1 and `rst_done` = 1 at edge 37.
- **Lock timeout to error.** `pll_locked` = 0 forever.
  - Three PLL_WAIT intervals of 64 cycles each; `retry_cnt` steps 1, 2, 3.
  - ERROR entered after the third timeout with `lock_err` = 1 and `pll_rst` = 1.
  - A `sw_reset_req` pulse returns the FSM to PLL_RST with `retry_cnt` = 0.
- **Late lock.** Lock asserted at cycle 40 of the second PLL_WAIT.
  - `retry_cnt` = 1, CORE_HOLD is reached, then RUN.
- **Lock loss in RUN.** Drop `pll_locked` for 10 cycles.
  - `core_rst_n` falls 3 cycles after the drop, state = PLL_RST, `retry_cnt` unchanged.
  - RUN is re-reached after the full sequence once lock returns.
- **`ninit_done` rises in CORE_HOLD.**
  - IDLE 3 cycles later with `pll_rst` = 1.
  - `sw_reset_req` in IDLE has no effect.
- **Asynchronous reset mid-PLL_WAIT.**
  - All outputs at reset values before the next clock edge.
  - The sequence restarts from IDLE after `rst_n` is released.

Source files
------------

// File: rtl/reset_release_sequencer.sv
// Ordered reset release: gates PLL reset on config done, waits for lock
// with timeout/retry, then releases the core reset after a hold period.
`timescale 1ns/1ps
module reset_release_sequencer #(
  parameter int SYNC_STAGES     = 3,
  parameter int HOLD_CYCLES     = 16,
  parameter int PLL_WAIT_CYCLES = 256,
  parameter int MAX_RETRIES     = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ninit_done,
  input  logic       pll_locked,
  input  logic       sw_reset_req,
  output logic       pll_rst,
  output logic       core_rst_n,
  output logic       rst_done,
  output logic       lock_err,
  output logic [3:0] retry_cnt,
  output logic [2:0] state
);

  localparam int SPAN = (HOLD_CYCLES > PLL_WAIT_CYCLES) ?
                        HOLD_CYCLES : PLL_WAIT_CYCLES;
  localparam int CW = $clog2(SPAN) + 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(PLL_WAIT_CYCLES - 1);
  localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PLL_RST   = 3'd1,
    PLL_WAIT  = 3'd2,
    CORE_HOLD = 3'd3,
    RUN       = 3'd4,
    ERROR     = 3'd5
  } state_t;

  logic [SYNC_STAGES-1:0] init_sync;
  logic [SYNC_STAGES-1:0] lock_sync;
  logic init_s;
  logic lock_s;

  state_t state_q;
  state_t state_nxt;
  logic [CW-1:0] cnt_q;
  logic [3:0] retry_q;
  logic [3:0] retry_nxt;
  logic restart;

  // init syncs to "not done", lock syncs to "not locked"
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_sync <= '1;
      lock_sync <= '0;
    end else begin
      init_sync <= {init_sync[SYNC_STAGES-2:0], ninit_done};
      lock_sync <= {lock_sync[SYNC_STAGES-2:0], pll_locked};
    end
  end

  assign init_s = init_sync[SYNC_STAGES-1];
  assign lock_s = lock_sync[SYNC_STAGES-1];

  always_comb begin
    state_nxt = state_q;
    retry_nxt = retry_q;
    restart   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!init_s) state_nxt = PLL_RST;
      end
      PLL_RST: begin
        if (cnt_q == HOLD_LAST) state_nxt = PLL_WAIT;
      end
      PLL_WAIT: begin
        if (lock_s) begin
          state_nxt = CORE_HOLD;
        end else if (cnt_q == WAIT_LAST) begin
          retry_nxt = retry_q + 4'd1;
          state_nxt = (retry_nxt == RETRY_LIMIT) ? ERROR : PLL_RST;
        end
      end
      CORE_HOLD: begin
        if (!lock_s) state_nxt = PLL_RST;
        else if (cnt_q == HOLD_LAST) state_nxt = RUN;
      end
      RUN: begin
        if (!lock_s) state_nxt = PLL_RST;
      end
      ERROR: begin
        state_nxt = ERROR;
      end
      default: state_nxt = IDLE;
    endcase
    if (state_q != IDLE) begin
      if (init_s) begin
        state_nxt = IDLE;
      end else if (sw_reset_req) begin
        state_nxt = PLL_RST;
        retry_nxt = '0;
        restart   = 1'b1;
      end
    end
    if (state_nxt == IDLE) retry_nxt = '0;
  end

  // Outputs registered from the next state so they track state exactly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      retry_q    <= '0;
      pll_rst    <= 1'b1;
      core_rst_n <= 1'b0;
      rst_done   <= 1'b0;
      lock_err   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      retry_q <= retry_nxt;
      if (state_nxt != state_q || restart) cnt_q <= '0;
      else if (cnt_q != {CW{1'b1}}) cnt_q <= cnt_q + 1'b1;
      pll_rst    <= (state_nxt == IDLE) || (state_nxt == PLL_RST) ||
                    (state_nxt == ERROR);
      core_rst_n <= (state_nxt == RUN);
      rst_done   <= (state_nxt == RUN);
      lock_err   <= (state_nxt == ERROR);
    end
  end

  assign state     = state_q;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_reset_release_sequencer.sv
// Directed bench for reset_release_sequencer: expectations are queued
// against an edge number and compared on the following falling edge.
`timescale 1ns/1ps
module tb_reset_release_sequencer;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PRST  = 3'd1;
  localparam logic [2:0] S_PWAIT = 3'd2;
  localparam logic [2:0] S_CHOLD = 3'd3;
  localparam logic [2:0] S_RUN   = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;

  logic clk;
  logic rst_n;
  logic ninit_done;
  logic pll_locked;
  logic sw_reset_req;
  logic pll_rst;
  logic core_rst_n;
  logic rst_done;
  logic lock_err;
  logic [3:0] retry_cnt;
  logic [2:0] state;

  typedef struct {
    int         cyc;
    string      tag;
    logic [2:0] st;
    logic [3:0] rc;
  } exp_t;

  exp_t q[$];
  int edge_n = 0;
  int n_checks = 0;
  int n_fail = 0;

  reset_release_sequencer #(
    .SYNC_STAGES(3),
    .HOLD_CYCLES(16),
    .PLL_WAIT_CYCLES(64),
    .MAX_RETRIES(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ninit_done(ninit_done),
    .pll_locked(pll_locked),
    .sw_reset_req(sw_reset_req),
    .pll_rst(pll_rst),
    .core_rst_n(core_rst_n),
    .rst_done(rst_done),
    .lock_err(lock_err),
    .retry_cnt(retry_cnt),
    .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic check_now(string tag, logic [2:0] st, logic [3:0] rc);
    logic [10:0] obs;
    logic [10:0] req;
    obs = {state, pll_rst, core_rst_n, rst_done, lock_err, retry_cnt};
    req = {st,
           (st == S_IDLE) || (st == S_PRST) || (st == S_ERR),
           st == S_RUN, st == S_RUN, st == S_ERR, rc};
    n_checks++;
    assert (obs === req) else begin
      n_fail++;
      $error("FAIL %s edge=%0d got st=%0d pr=%b crn=%b rd=%b le=%b rc=%0d want st=%0d rc=%0d",
             tag, edge_n, state, pll_rst, core_rst_n, rst_done, lock_err,
             retry_cnt, st, rc);
    end
  endtask

  function automatic void expect_at(int cyc, string tag,
                                    logic [2:0] st, logic [3:0] rc);
    exp_t e;
    e.cyc = cyc;
    e.tag = tag;
    e.st  = st;
    e.rc  = rc;
    q.push_back(e);
  endfunction

  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc == edge_n) begin
        check_now(q[i].tag, q[i].st, q[i].rc);
        q.delete(i);
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic goto(int e);
    while (edge_n < e) begin
      @(posedge clk);
      #1;
    end
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog edge=%0d", edge_n);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b;
    rst_n = 1'b0;
    ninit_done = 1'b1;
    pll_locked = 1'b0;
    sw_reset_req = 1'b0;
    tick(3);
    check_now("reset_state", S_IDLE, 4'd0);
    rst_n = 1'b1;

    // nominal release
    b = edge_n;
    ninit_done = 1'b0;
    pll_locked = 1'b1;
    expect_at(b + 3,  "nom_idle", S_IDLE, 4'd0);
    expect_at(b + 4,  "nom_pllrst", S_PRST, 4'd0);
    expect_at(b + 19, "nom_pllrst_end", S_PRST, 4'd0);
    expect_at(b + 20, "nom_pllwait", S_PWAIT, 4'd0);
    expect_at(b + 21, "nom_chold", S_CHOLD, 4'd0);
    expect_at(b + 36, "nom_chold_end", S_CHOLD, 4'd0);
    expect_at(b + 37, "nom_run", S_RUN, 4'd0);
    goto(b + 40);

    // lock loss in RUN for 10 cycles
    b = edge_n;
    pll_locked = 1'b0;
    expect_at(b + 3,  "loss_still_run", S_RUN, 4'd0);
    expect_at(b + 4,  "loss_pllrst", S_PRST, 4'd0);
    expect_at(b + 20, "loss_pllwait", S_PWAIT, 4'd0);
    expect_at(b + 21, "loss_chold", S_CHOLD, 4'd0);
    expect_at(b + 37, "loss_rerun", S_RUN, 4'd0);
    goto(b + 10);
    pll_locked = 1'b1;
    goto(b + 40);

    // ninit_done rises in RUN
    b = edge_n;
    ninit_done = 1'b1;
    expect_at(b + 3, "init_run_hold", S_RUN, 4'd0);
    expect_at(b + 4, "init_run_idle", S_IDLE, 4'd0);
    goto(b + 6);

    // ninit_done rises in CORE_HOLD
    b = edge_n;
    ninit_done = 1'b0;
    expect_at(b + 21, "ch_enter", S_CHOLD, 4'd0);
    expect_at(b + 28, "ch_hold", S_CHOLD, 4'd0);
    expect_at(b + 29, "ch_idle", S_IDLE, 4'd0);
    goto(b + 25);
    ninit_done = 1'b1;
    goto(b + 31);

    // sw_reset_req in IDLE is ignored
    b = edge_n;
    expect_at(b + 1, "sw_idle_1", S_IDLE, 4'd0);
    expect_at(b + 3, "sw_idle_3", S_IDLE, 4'd0);
    sw_reset_req = 1'b1;
    tick(1);
    sw_reset_req = 1'b0;
    goto(b + 4);

    // lock timeout to error
    b = edge_n;
    ninit_done = 1'b0;
    pll_locked = 1'b0;
    expect_at(b + 20,  "to_wait1", S_PWAIT, 4'd0);
    expect_at(b + 83,  "to_wait1_end", S_PWAIT, 4'd0);
    expect_at(b + 84,  "to_retry1", S_PRST, 4'd1);
    expect_at(b + 100, "to_wait2", S_PWAIT, 4'd1);
    expect_at(b + 163, "to_wait2_end", S_PWAIT, 4'd1);
    expect_at(b + 164, "to_retry2", S_PRST, 4'd2);
    expect_at(b + 243, "to_wait3_end", S_PWAIT, 4'd2);
    expect_at(b + 244, "to_error", S_ERR, 4'd3);
    expect_at(b + 250, "to_error_sticky", S_ERR, 4'd3);
    expect_at(b + 251, "to_sw_restart", S_PRST, 4'd0);
    goto(b + 250);
    sw_reset_req = 1'b1;
    tick(1);
    sw_reset_req = 1'b0;

    // late lock in second PLL_WAIT (b = PLL_RST entry)
    b = edge_n;
    expect_at(b + 16,  "late_wait1", S_PWAIT, 4'd0);
    expect_at(b + 80,  "late_retry1", S_PRST, 4'd1);
    expect_at(b + 96,  "late_wait2", S_PWAIT, 4'd1);
    expect_at(b + 138, "late_wait2_hold", S_PWAIT, 4'd1);
    expect_at(b + 139, "late_chold", S_CHOLD, 4'd1);
    expect_at(b + 155, "late_run", S_RUN, 4'd1);
    goto(b + 135);
    pll_locked = 1'b1;
    goto(b + 158);

    // lock and timeout on the same edge: lock wins
    b = edge_n;
    pll_locked = 1'b0;
    expect_at(b + 3,   "tie_run", S_RUN, 4'd1);
    expect_at(b + 4,   "tie_pllrst", S_PRST, 4'd1);
    expect_at(b + 20,  "tie_wait", S_PWAIT, 4'd1);
    expect_at(b + 83,  "tie_wait_end", S_PWAIT, 4'd1);
    expect_at(b + 84,  "tie_lock_wins", S_CHOLD, 4'd1);
    expect_at(b + 100, "tie_run_again", S_RUN, 4'd1);
    goto(b + 80);
    pll_locked = 1'b1;
    goto(b + 103);

    // asynchronous reset in the middle of PLL_WAIT
    b = edge_n;
    pll_locked = 1'b0;
    expect_at(b + 4,  "ar_pllrst", S_PRST, 4'd1);
    expect_at(b + 20, "ar_wait", S_PWAIT, 4'd1);
    goto(b + 30);
    #1;
    rst_n = 1'b0;
    #1;
    check_now("ar_async", S_IDLE, 4'd0);
    tick(2);
    pll_locked = 1'b1;
    rst_n = 1'b1;
    b = edge_n;
    expect_at(b + 3,  "ar_restart_idle", S_IDLE, 4'd0);
    expect_at(b + 4,  "ar_restart_pllrst", S_PRST, 4'd0);
    expect_at(b + 37, "ar_restart_run", S_RUN, 4'd0);
    goto(b + 40);

    n_checks++;
    assert (q.size() == 0) else begin
      n_fail++;
      $error("FAIL pending_expectations got=%0d want=0", q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
